// File: rtl/maclaurin_pkg.sv
// Shared definitions for the Maclaurin series scheduler.
//   - Batch and pipeline constants (sample count, short/long latency).
//   - FSM state encoding (IDLE, CFG, RUN, DRAIN, ERR).
//   - lat_of(): maps a term count onto the pipeline latency it needs.
package maclaurin_pkg;

    localparam int SAMPLES     = 20;
    localparam int LAT_SHORT   = 3;
    localparam int LAT_LONG    = 7;
    localparam int X_W         = 8;
    localparam int N_MIN       = 2;
    localparam int N_SHORT_MAX = 4;
    localparam int N_W         = 3;
    localparam int CNT_W       = $clog2(SAMPLES + 1);
    localparam int LAT_W       = $clog2(LAT_LONG + 1);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CFG   = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_ERR   = 3'd4;

    // Short series fit in the 3-stage tail; longer ones need the 7-stage tail.
    function automatic logic [LAT_W-1:0] lat_of(input logic [N_W-1:0] n);
        logic [LAT_W-1:0] lat;
        if (n <= N_W'(N_SHORT_MAX)) begin
            lat = LAT_W'(LAT_SHORT);
        end else begin
            lat = LAT_W'(LAT_LONG);
        end
        return lat;
    endfunction

endpackage

// File: rtl/maclaurin_tok_track.sv
// Token tracker: one valid bit per datapath stage, shifted in lock-step with
// the datapath stage enable.
//   clk, rst    : clock, asynchronous active-low reset
//   clr         : synchronous clear of every token (new batch)
//   shift       : stage enable, the register advances when high
//   din         : token entering stage 0 (sample accepted this cycle)
//   lat         : selected latency, tail tap is tok[lat-1]
//   y_valid     : tail token
//   empty       : no token will remain in the active stages after this edge
module maclaurin_tok_track
    import maclaurin_pkg::*;
#(
    parameter int DEPTH = LAT_LONG
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             din,
    input  logic [LAT_W-1:0] lat,
    output logic             y_valid,
    output logic             empty
);

    logic [DEPTH-1:0] tok_r;
    logic             tail_s;
    logic             live_s;

    // Token shift register, frozen while the pipe is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_r <= {DEPTH{1'b0}};
        end else if (clr) begin
            tok_r <= {DEPTH{1'b0}};
        end else if (shift) begin
            tok_r <= {tok_r[DEPTH-2:0], din};
        end else begin
            tok_r <= tok_r;
        end
    end

    // Tail tap and look-ahead emptiness. Bits at or beyond lat are ignored,
    // so tokens that walked past the tail of a short pipe never count.
    // When shifting, the tail token leaves this edge, so only the stages
    // below it (plus an incoming token) keep the tracker busy; this lets
    // done coincide with the final result being handed downstream.
    always_comb begin
        tail_s = 1'b0;
        live_s = shift & din;
        for (int i = 0; i < DEPTH; i++) begin
            tail_s = tail_s | (tok_r[i] & ((i + 1) == int'(lat)));
            if (shift) begin
                live_s = live_s | (tok_r[i] & ((i + 2) <= int'(lat)));
            end else begin
                live_s = live_s | (tok_r[i] & ((i + 1) <= int'(lat)));
            end
        end
    end

    assign y_valid = tail_s;
    assign empty   = ~live_s;

endmodule

// File: rtl/maclaurin_sched.sv
// Batch scheduler for the pipelined Maclaurin series datapath.
// Latches the term count on start, selects the pipeline latency, admits
// SAMPLES inputs through a valid/ready handshake, tracks in-flight tokens,
// stalls the whole pipe on downstream backpressure, drains and pulses done.
//   clk, rst          : clock, asynchronous active-low reset
//   start, n_in       : batch start pulse and term count
//   x_in, x_valid     : sample source, x_ready acknowledges
//   pipe_en, pipe_x   : datapath stage enable and stage-0 sample
//   pipe_n            : term count held for the batch
//   pipe_ovf          : datapath overflow at the selected tail
//   y_valid, y_ready  : result handshake
//   ovf, ovf_sticky   : qualified overflow and its batch-long sticky copy
//   busy, done, error : status
module maclaurin_sched
    import maclaurin_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_W-1:0]        n_in,
    input  logic signed [X_W-1:0] x_in,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic                  pipe_en,
    output logic signed [X_W-1:0] pipe_x,
    output logic [N_W-1:0]        pipe_n,
    input  logic                  pipe_ovf,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  ovf,
    output logic                  ovf_sticky,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      count_r;
    logic [LAT_W-1:0]      lat_r;
    logic [N_W-1:0]        pipe_n_r;
    logic signed [X_W-1:0] pipe_x_r;
    logic                  ovf_sticky_r;

    logic                  pipe_en_s;
    logic                  x_ready_s;
    logic                  accept_s;
    logic                  start_idle_s;
    logic                  n_ok_s;
    logic                  y_valid_s;
    logic                  tok_empty_s;
    logic                  ovf_s;

    // A start is only honoured when no batch is in flight.
    assign start_idle_s = start & ((state_r == ST_IDLE) | (state_r == ST_ERR));
    assign n_ok_s       = (n_in >= N_W'(N_MIN));

    // The pipe freezes only when a result is waiting and nobody takes it;
    // an empty tail lets bubbles collapse. Held low during reset so every
    // output reads zero while rst is asserted.
    assign pipe_en_s = rst & ~(y_valid_s & ~y_ready);
    assign x_ready_s = (state_r == ST_RUN) & pipe_en_s & (count_r < CNT_W'(SAMPLES));
    assign accept_s  = x_valid & x_ready_s;
    assign ovf_s     = pipe_ovf & y_valid_s;

    maclaurin_tok_track #(
        .DEPTH (LAT_LONG)
    ) u_tok (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_idle_s),
        .shift   (pipe_en_s),
        .din     (accept_s),
        .lat     (lat_r),
        .y_valid (y_valid_s),
        .empty   (tok_empty_s)
    );

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = n_ok_s ? ST_CFG : ST_ERR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CFG: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (accept_s && (count_r == CNT_W'(SAMPLES - 1))) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (tok_empty_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_ERR: begin
                if (start && n_ok_s) begin
                    state_nxt_s = ST_CFG;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Batch configuration: term count and latency, stable until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_n_r <= {N_W{1'b0}};
            lat_r    <= LAT_W'(LAT_SHORT);
        end else if (start_idle_s && n_ok_s) begin
            pipe_n_r <= n_in;
            lat_r    <= lat_of(n_in);
        end else begin
            pipe_n_r <= pipe_n_r;
            lat_r    <= lat_r;
        end
    end

    // Admitted-sample counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (start_idle_s) begin
            count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Stage-0 sample register; holds across stalls because accept needs pipe_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_x_r <= {X_W{1'b0}};
        end else if (accept_s) begin
            pipe_x_r <= x_in;
        end else begin
            pipe_x_r <= pipe_x_r;
        end
    end

    // Sticky overflow: set when a flagged result is actually consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky_r <= 1'b0;
        end else if (start_idle_s) begin
            ovf_sticky_r <= 1'b0;
        end else if (ovf_s && y_ready) begin
            ovf_sticky_r <= 1'b1;
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
        end
    end

    assign x_ready    = x_ready_s;
    assign pipe_en    = pipe_en_s;
    assign pipe_x     = pipe_x_r;
    assign pipe_n     = pipe_n_r;
    assign y_valid    = y_valid_s;
    assign ovf        = ovf_s;
    assign ovf_sticky = ovf_sticky_r;
    assign busy       = (state_r == ST_CFG) | (state_r == ST_RUN) | (state_r == ST_DRAIN);
    assign done       = (state_r == ST_DRAIN) & tok_empty_s;
    assign error      = (state_r == ST_ERR);

endmodule

// File: doc/maclaurin_sched.md
Name: maclaurin_sched

Overview:
- Controller that sequences the pipelined Maclaurin series datapath for one batch of X samples.
- On start it latches the term count N and selects pipeline latency (3 stages for N<=4, 7 stages for N>=5).
- It admits SAMPLES inputs through a valid/ready handshake, tracks in-flight tokens, stalls the pipe on downstream backpressure, drains, then signals done.
- Sits between the sample source and the datapath registers; drives their enables and qualifies their outputs.

Parameters:
- SAMPLES, 20, inputs per batch.
- LAT_SHORT, 3, pipeline latency when N<=4.
- LAT_LONG, 7, pipeline latency when N>=5; also the depth of the token shift register.
- X_W, 8, sample width (signed).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a batch.
- n_in  in  3  term count, sampled on start.
- x_in  in  X_W  signed sample.
- x_valid  in  1  source has a sample.
- x_ready  out  1  sample accepted this cycle when x_valid=1.
- pipe_en  out  1  global stage enable for the datapath.
- pipe_x  out  X_W  sample injected into stage 0.
- pipe_n  out  3  latched N, held stable for the batch.
- pipe_ovf  in  1  datapath overflow flag at the selected tail stage.
- y_valid  out  1  tail token valid.
- y_ready  in  1  downstream accepts the result.
- ovf  out  1  pipe_ovf qualified by y_valid.
- ovf_sticky  out  1  any overflow seen in the batch.
- busy  out  1  state is CFG, RUN or DRAIN.
- done  out  1  one-cycle pulse when the batch has fully drained.
- error  out  1  invalid N latched.

Behaviour:
- Reset (rst=0), applied asynchronously:
  - state=IDLE; tokens=0; count=0; pipe_n=0; pipe_x=0.
  - All outputs 0.
- States: IDLE, CFG, RUN, DRAIN, ERR.
- IDLE:
  - start with n_in in 2..7 -> CFG; latch pipe_n; lat_sel = (n_in<=4 ? LAT_SHORT : LAT_LONG).
  - start with n_in<2 -> ERR.
  - Clear ovf_sticky and count on any start.
- CFG: one cycle, no admission -> RUN. Gives the datapath one cycle to load its coefficients.
- ERR: error=1, x_ready=0. A start with valid N -> CFG and clears error; a start with invalid N stays in ERR.
- Token shift register tok[LAT_LONG-1:0]:
  - Shifts when pipe_en=1.
  - tok[0] takes the accept bit.
  - Tail = tok[lat_sel-1]; y_valid = tail.
- pipe_en = !(y_valid && !y_ready). When y_valid=0 the pipe advances even while empty, so bubbles collapse.
- Admission in RUN:
  - x_ready = (state==RUN) && pipe_en && (count<SAMPLES).
  - accept = x_valid && x_ready; on accept pipe_x<=x_in and count++.
  - When pipe_en=0, pipe_x holds its value.
- RUN -> DRAIN on the cycle count reaches SAMPLES.
- DRAIN -> IDLE when tok is all zero; done pulses in that same cycle.
- ovf = pipe_ovf && y_valid. ovf_sticky sets on any cycle where ovf=1 && y_ready=1.
- start while busy=1: ignored; batch continues; no error.
- Every admitted sample emerges exactly once, in order, after lat_sel enabled cycles.
- Throughput is 1 sample/cycle with no stall.
- Asserting reset mid-batch discards all in-flight tokens. No y_valid appears after reset is released.

Decomposition:
- Shared package maclaurin_pkg holds:
  - state enum: IDLE, CFG, RUN, DRAIN, ERR.
  - constants N_MIN=2, LAT_SHORT, LAT_LONG, SAMPLES.
  - function lat_of(n) returning the latency for a term count.
- One natural sub-module: maclaurin_tok_track, the enable-gated token shift register with selectable tail tap. It exports y_valid and an empty flag.

Test Plan:
- N=3, x_valid=1 continuously, y_ready=1 -> 20 accepts on consecutive cycles; first y_valid 3 cycles after the first accept; 20 y_valid cycles; done 3 cycles after the last accept; busy=0 afterwards.
- N=7, same stimulus -> first y_valid 7 cycles after the first accept; done 7 cycles after the last accept; pipe_n=7 throughout.
- N=5, y_ready held 0 for 4 cycles mid-stream -> pipe_en=0, x_ready=0, and y_valid and pipe_x hold for exactly 4 cycles; no sample lost or duplicated; order preserved.
- start with n_in=1 -> ERR, error=1, x_ready=0; then start with n_in=4 -> error=0, CFG, and a normal batch runs.
- pipe_ovf=1 on the 10th result with N=2 -> ovf=1 for that one cycle; ovf_sticky=1 until the next start.
- rst=0 after 8 accepts (N=7) -> all outputs 0 immediately; after release, no y_valid until a new start.
